// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - shared types and constants for the brick bump animator
package block_pkg;

    localparam int NUM_BLOCKS_MAX = 8;
    localparam int BLOCK_Y_W      = 10;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        SPENT
    } bump_state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/block_bump_fsm.sv
// rtl/block_bump_fsm.sv - per-brick rise/fall/spent bump state machine
module bump_fsm
    import block_pkg::*;
#(
    parameter int unsigned BUMP_HEIGHT = 8,
    parameter int unsigned BUMP_STEP   = 2
) (
    input  logic       frame_clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       hit,
    output logic [3:0] offset,
    output logic       started
);

    localparam logic [4:0] HEIGHT5 = 5'(BUMP_HEIGHT);
    localparam logic [4:0] STEP5   = 5'(BUMP_STEP);

    bump_state_t state_q, state_d;
    logic [3:0]  offset_q, offset_d;
    logic [4:0]  up_sum;

    assign up_sum = {1'b0, offset_q} + STEP5;

    // started is the combinational "bump begins at this edge" term; the top registers it
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        started  = 1'b0;
        if (clear) begin
            state_d  = IDLE;
            offset_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        started = 1'b1;
                        if (STEP5 >= HEIGHT5) begin
                            state_d  = FALL;
                            offset_d = HEIGHT5[3:0];
                        end else begin
                            state_d  = RISE;
                            offset_d = STEP5[3:0];
                        end
                    end
                end
                RISE: begin
                    if (up_sum >= HEIGHT5) begin
                        state_d  = FALL;
                        offset_d = HEIGHT5[3:0];
                    end else begin
                        offset_d = up_sum[3:0];
                    end
                end
                FALL: begin
                    if ({1'b0, offset_q} <= STEP5) begin
                        state_d  = SPENT;
                        offset_d = 4'd0;
                    end else begin
                        offset_d = offset_q - STEP5[3:0];
                    end
                end
                SPENT: begin
                    offset_d = 4'd0;
                end
                default: begin
                    state_d  = IDLE;
                    offset_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            offset_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
        end
    end

    assign offset = offset_q;

endmodule

// File: rtl/block_bump.sv
// rtl/block_bump.sv - brick bump animator top; optional score counter via BLOCK_BUMP_SCORE_EN
module block_bump
    import block_pkg::*;
#(
    parameter int unsigned NUM_BLOCKS  = 8,
    parameter int unsigned BASE_Y_LO   = 250,
    parameter int unsigned BASE_Y_HI   = 200,
    parameter int unsigned BUMP_HEIGHT = 8,
    parameter int unsigned BUMP_STEP   = 2,
    parameter int unsigned SCORE_MAX   = 999
) (
    input  logic                               frame_clk,
    input  logic                               reset_n,
    input  logic [7:0]                         blockflags,
    input  logic signed [31:0]                 page_index,
    input  logic [1:0]                         game_state,
    output logic [NUM_BLOCKS*BLOCK_Y_W-1:0]    blocky,
    output logic [7:0]                         hit_pulse,
    output logic [15:0]                        score
);

    if (NUM_BLOCKS > NUM_BLOCKS_MAX || BUMP_STEP < 1 || BUMP_STEP > BUMP_HEIGHT ||
        BUMP_HEIGHT > 15 || SCORE_MAX > 65535) begin : g_bad_params
        $error("block_bump: parameter out of range");
    end

    logic [7:0]         prev_flags_q, prev_flags_d;
    logic signed [31:0] prev_page_q;
    logic [7:0]         hit_pulse_q;
    logic [7:0]         rise;
    logic [7:0]         started;
    logic               restart;
    logic               clear;

    assign restart = (game_state == 2'b10);
    assign clear   = (page_index != prev_page_q) || restart;
    assign rise    = blockflags & ~prev_flags_q;

    // zeroing the edge history on clear lets a flag still set on the new page bump again
    assign prev_flags_d = clear ? 8'd0 : blockflags;

    always_ff @(posedge frame_clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_flags_q <= 8'd0;
            prev_page_q  <= 32'sd0;
            hit_pulse_q  <= 8'd0;
        end else begin
            prev_flags_q <= prev_flags_d;
            prev_page_q  <= page_index;
            hit_pulse_q  <= started;
        end
    end

    for (genvar i = 0; i < NUM_BLOCKS_MAX; i++) begin : g_blk
        if (i < NUM_BLOCKS) begin : g_on
            localparam logic [BLOCK_Y_W-1:0] BASE = (i < 4) ? BLOCK_Y_W'(BASE_Y_LO)
                                                            : BLOCK_Y_W'(BASE_Y_HI);
            logic [3:0] offset;

            bump_fsm #(
                .BUMP_HEIGHT (BUMP_HEIGHT),
                .BUMP_STEP   (BUMP_STEP)
            ) u_fsm (
                .frame_clk (frame_clk),
                .reset_n   (reset_n),
                .clear     (clear),
                .hit       (rise[i]),
                .offset    (offset),
                .started   (started[i])
            );

            assign blocky[i*BLOCK_Y_W +: BLOCK_Y_W] = BASE - {{(BLOCK_Y_W-4){1'b0}}, offset};
        end else begin : g_off
            assign started[i] = 1'b0;
        end
    end

    assign hit_pulse = hit_pulse_q;

`ifdef BLOCK_BUMP_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [16:0] score_sum;

    assign score_sum = {1'b0, score_q} + {13'd0, popcount8(started)};

    always_comb begin
        score_d = score_q;
        if (restart) begin
            score_d = 16'd0;
        end else if (score_sum >= 17'(SCORE_MAX)) begin
            score_d = 16'(SCORE_MAX);
        end else begin
            score_d = score_sum[15:0];
        end
    end

    always_ff @(posedge frame_clk or negedge reset_n) begin
        if (!reset_n) begin
            score_q <= 16'd0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;
`else
    assign score = 16'd0;
`endif

endmodule
